// File: rtl/frame_loader.sv
// -----------------------------------------------------------------------------
// frame_loader
// Writer side of the HUB75 dual-half frame buffer. Unpacks a raster byte stream
// of RGB444 pixels (3 bytes -> 2 pixels, high nibble first) and writes each
// pixel into the buffer word {top-half px, bottom-half px} at
// address col + PX_PER_ROW*(row mod ROWS/2), selecting the lane by row half.
//
// Ports:
//   clk_25MHz   system clock
//   rst         synchronous reset, active-high
//   sof_in      start-of-frame strobe (restarts the frame from any state)
//   in_data     stream byte; in_valid/in_ready handshake
//   buf_waddr   buffer word address (bank bit as MSB when double-buffered)
//   buf_wdata   pixel replicated in both 12-bit lanes
//   buf_we_hi   write enable for bits [23:12] (top half rows)
//   buf_we_lo   write enable for bits [11:0]  (bottom half rows)
//   frame_done  1-cycle pulse alongside the last pixel write
//   frame_abort 1-cycle pulse when a started frame is restarted by sof_in
//   disp_bank   (FRAME_DBL_BUF_EN only) bank the renderer should read
//
// Optional feature: define FRAME_DBL_BUF_EN for a ping-pong buffer; the write
// bank toggles the cycle after frame_done and disp_bank is its inverse.
// -----------------------------------------------------------------------------
module frame_loader #(
    parameter int unsigned PX_PER_ROW = 96,
    parameter int unsigned ROWS       = 64,
    parameter int unsigned ADDR_W     = 12
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    input  logic              sof_in,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
`ifdef FRAME_DBL_BUF_EN
    output logic [ADDR_W:0]   buf_waddr,
    output logic              disp_bank,
`else
    output logic [ADDR_W-1:0] buf_waddr,
`endif
    output logic [23:0]       buf_wdata,
    output logic              buf_we_hi,
    output logic              buf_we_lo,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int unsigned COL_W     = (PX_PER_ROW > 1) ? $clog2(PX_PER_ROW) : 1;
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned HALF_ROWS = ROWS / 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [7:0]          hold_q, hold_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                touched_q, touched_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [23:0]         wdata_q, wdata_d;
    logic                we_hi_q, we_hi_d;
    logic                we_lo_q, we_lo_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;

    logic                accept_c;
    logic                px_done_c;
    logic                last_px_c;
    logic                top_half_c;
    logic [ROW_W-1:0]    half_row_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [11:0]         px_c;

    // Handshake: sof_in takes priority over a same-cycle byte
    assign in_ready   = (state_q == S_ACTIVE) && !sof_in;
    assign accept_c   = in_valid && in_ready;

    // A pixel completes on the 2nd and 3rd byte of each triple
    assign px_done_c  = accept_c && (phase_q != 2'd0);
    assign last_px_c  = px_done_c
                        && (col_q == COL_W'(PX_PER_ROW - 1))
                        && (row_q == ROW_W'(ROWS - 1));

    // Row folding onto the buffer half
    assign top_half_c = (row_q < ROW_W'(HALF_ROWS));
    assign half_row_c = top_half_c ? row_q : (row_q - ROW_W'(HALF_ROWS));
    assign addr_c     = ADDR_W'(col_q) + (ADDR_W'(PX_PER_ROW) * ADDR_W'(half_row_c));

    // State and datapath registers
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            hold_q    <= 8'd0;
            col_q     <= '0;
            row_q     <= '0;
            touched_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= 24'd0;
            we_hi_q   <= 1'b0;
            we_lo_q   <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            hold_q    <= hold_d;
            col_q     <= col_d;
            row_q     <= row_d;
            touched_q <= touched_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            we_hi_q   <= we_hi_d;
            we_lo_q   <= we_lo_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (sof_in) begin
            state_d = S_ACTIVE;
        end else if (last_px_c) begin
            state_d = S_DONE;
        end
    end

    // Unpacking, raster counters and registered buffer-write outputs
    always_comb begin
        phase_d   = phase_q;
        hold_d    = hold_q;
        col_d     = col_q;
        row_d     = row_q;
        touched_d = touched_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        we_hi_d   = 1'b0;
        we_lo_d   = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        px_c      = 12'd0;

        if (sof_in) begin
            phase_d   = 2'd0;
            hold_d    = 8'd0;
            col_d     = '0;
            row_d     = '0;
            touched_d = 1'b0;
            abort_d   = (state_q == S_ACTIVE) && touched_q;
        end else if (accept_c) begin
            touched_d = 1'b1;
            unique case (phase_q)
                2'd0: begin
                    hold_d  = in_data;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    px_c    = {hold_q, in_data[7:4]};
                    hold_d  = {4'h0, in_data[3:0]};
                    phase_d = 2'd2;
                end
                default: begin
                    px_c    = {hold_q[3:0], in_data};
                    hold_d  = 8'd0;
                    phase_d = 2'd0;
                end
            endcase

            if (px_done_c) begin
                waddr_d = addr_c;
                wdata_d = {px_c, px_c};
                we_hi_d = top_half_c;
                we_lo_d = !top_half_c;
                done_d  = last_px_c;
                if (last_px_c) begin
                    col_d = '0;
                    row_d = '0;
                end else if (col_q == COL_W'(PX_PER_ROW - 1)) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
        end
    end

`ifdef FRAME_DBL_BUF_EN
    logic bank_q, bank_d;
    logic disp_bank_q;

    // Write bank flips once the completed frame's last write has gone out
    always_comb begin
        bank_d = bank_q;
        if (done_q) begin
            bank_d = ~bank_q;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            bank_q      <= 1'b0;
            disp_bank_q <= 1'b1;
        end else begin
            bank_q      <= bank_d;
            disp_bank_q <= ~bank_d;
        end
    end

    assign buf_waddr = {bank_q, waddr_q};
    assign disp_bank = disp_bank_q;
`else
    assign buf_waddr = waddr_q;
`endif

    assign buf_wdata   = wdata_q;
    assign buf_we_hi   = we_hi_q;
    assign buf_we_lo   = we_lo_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_frame_loader
// Scoreboard bench: the driver feeds random bytes into a pixel-level model of
// the frame (pixel index -> col/row -> address), pushing expected writes and
// abort pulses into queues; an independent monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_frame_loader;

    localparam int PXR    = 96;
    localparam int NROWS  = 64;
    localparam int AW     = 12;
    localparam int NPIX   = PXR * NROWS;
    localparam int NBYTES = NPIX * 3 / 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sof_in;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
`ifdef FRAME_DBL_BUF_EN
    logic [AW:0]   buf_waddr;
    logic          disp_bank;
`else
    logic [AW-1:0] buf_waddr;
`endif
    logic [23:0]   buf_wdata;
    logic          buf_we_hi;
    logic          buf_we_lo;
    logic          frame_done;
    logic          frame_abort;

    frame_loader #(.PX_PER_ROW(PXR), .ROWS(NROWS), .ADDR_W(AW)) dut (
        .clk_25MHz   (clk),
        .rst         (rst),
        .sof_in      (sof_in),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .buf_waddr   (buf_waddr),
`ifdef FRAME_DBL_BUF_EN
        .disp_bank   (disp_bank),
`endif
        .buf_wdata   (buf_wdata),
        .buf_we_hi   (buf_we_hi),
        .buf_we_lo   (buf_we_lo),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          addr;
        logic        hi;
        logic        lo;
        logic [23:0] data;
        logic        done;
        logic        bank;
        int          cyc;
    } wr_t;

    wr_t  exp_q[$];
    int   abort_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    // Reference model state
    bit        m_active  = 0;
    bit        m_touched = 0;
    bit        m_bank    = 0;
    int        m_px      = 0;
    logic [7:0] m_part[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pixel k of the frame lands at col k%PXR, row k/PXR
    task automatic emit(input logic [11:0] px);
        wr_t e;
        int col, row;
        col    = m_px % PXR;
        row    = m_px / PXR;
        e.addr = col + PXR * (row % (NROWS / 2));
        e.hi   = (row < NROWS / 2);
        e.lo   = (row >= NROWS / 2);
        e.data = {px, px};
        e.done = (m_px == NPIX - 1);
        e.bank = m_bank;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        m_px++;
        if (e.done) begin
            m_active = 0;
            m_bank   = ~m_bank;
            done_exp++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] b0, b1;
        m_touched = 1;
        m_part.push_back(b);
        if (m_part.size() == 2) begin
            b0 = m_part[0];
            emit({b0, b[7:4]});
        end else if (m_part.size() == 3) begin
            b1 = m_part[1];
            emit({b1[3:0], b});
            m_part.delete();
        end
    endtask

    task automatic model_sof();
        if (m_active && m_touched) abort_q.push_back(cyc + 1);
        m_active  = 1;
        m_touched = 0;
        m_px      = 0;
        m_part.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        else model_byte(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_sof(input bit with_byte);
        sof_in   = 1'b1;
        in_valid = with_byte;
        in_data  = 8'($urandom);
        @(negedge clk);
        chk("ready_during_sof", in_ready, 0);
        model_sof();
        tick();
        sof_in   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap_pct);
        for (int i = 0; i < NBYTES; i++) begin
            while (int'($urandom_range(99)) < gap_pct) tick();
            send_byte(8'($urandom));
        end
    endtask

    task automatic check_blocked(input string name);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk(name, in_ready, 0);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: compare every buffer write and pulse against the queues
    always @(negedge clk) begin
        if (!rst) begin
            if (buf_we_hi || buf_we_lo) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("waddr", buf_waddr[AW-1:0], e.addr);
                    chk("wdata", buf_wdata, e.data);
                    chk("we_hi", buf_we_hi, e.hi);
                    chk("we_lo", buf_we_lo, e.lo);
                    chk("frame_done", frame_done, e.done);
                    chk("write_cycle", cyc, e.cyc);
`ifdef FRAME_DBL_BUF_EN
                    chk("bank_bit", buf_waddr[AW], e.bank);
                    chk("disp_bank", disp_bank, ~e.bank);
`endif
                end
            end else if (frame_done) begin
                chk("done_without_write", 1, 0);
            end
            if (frame_done) done_seen++;
            if (frame_abort) begin
                if (abort_q.size() == 0) chk("unexpected_abort", 1, 0);
                else chk("abort_cycle", cyc, abort_q.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b1;
        sof_in   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_we_hi", buf_we_hi, 0);
        chk("rst_we_lo", buf_we_lo, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_abort", frame_abort, 0);
        chk("rst_waddr", buf_waddr, 0);
        chk("rst_wdata", buf_wdata, 0);
`ifdef FRAME_DBL_BUF_EN
        chk("rst_disp_bank", disp_bank, 1);
`endif
        tick();
        rst = 1'b0;
        tick();
        chk("idle_in_ready", in_ready, 0);

        // Basic packing
        send_sof(0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        repeat (2) tick();
        chk("basic_pixels_drained", exp_q.size(), 0);

        // Restart of a touched frame, with a same-cycle byte that must be dropped
        send_sof(1);
        // Back-to-back sof on an untouched frame: no abort
        send_sof(0);
        send_byte(8'hA5);
        send_byte(8'h5A);
        // Pending write from the previous cycle completes alongside the abort
        send_sof(0);

        // Abort after 100 bytes, then restart at address 0
        for (int i = 0; i < 100; i++) send_byte(8'($urandom));
        send_sof(0);
        send_byte(8'h12);
        send_byte(8'h34);

        // Full frame back-to-back
        send_sof(0);
        send_frame(0);
        check_blocked("ready_after_done");

        // Full frame with random idle gaps; sof in DONE gives no abort
        send_sof(0);
        send_frame(30);
        check_blocked("ready_after_done_gaps");

        // Reset mid-frame
        send_sof(0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        repeat (2) tick();
        rst = 1'b1;
        m_active = 0; m_touched = 0; m_px = 0; m_part.delete(); m_bank = 0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_we", {buf_we_hi, buf_we_lo}, 0);
        chk("midrst_waddr", buf_waddr, 0);
        chk("midrst_wdata", buf_wdata, 0);
        tick();
        send_sof(0);
        send_byte(8'h9C);
        send_byte(8'h3E);

        repeat (4) tick();
        chk("writes_drained", exp_q.size(), 0);
        chk("aborts_drained", abort_q.size(), 0);
        chk("frames_done", done_seen, done_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
